// File: rtl/flatten_fc_pkg.sv
// Shared types and helpers for the flatten-to-FC input buffer and its sequencer.
package flatten_fc_pkg;

    typedef enum logic [2:0] {
        FILL,
        STREAM,
        EXEC,
        WAIT,
        DONE
    } ctrl_state_t;

    // Integer ceiling division for elaboration-time sizing.
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/ibuf_fill_counter.sv
// One channel's fill counter: counts accepted elements, saturates at IMG_SIZE,
// and withdraws ready once the channel's shift FIFO holds a whole image.
module ibuf_fill_counter #(
    parameter int IMG_SIZE   = 784,
    parameter int FILL_WIDTH = $clog2(IMG_SIZE + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic i_fill_en,
    input  logic i_valid,
    input  logic i_clr,
    output logic o_ready,
    output logic o_write_enable,
    output logic o_full
);

    logic [FILL_WIDTH-1:0] cnt_q;
    logic [FILL_WIDTH-1:0] cnt_d;

    assign o_full         = (cnt_q == FILL_WIDTH'(IMG_SIZE));
    assign o_ready        = i_fill_en && !o_full;
    assign o_write_enable = i_valid && o_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (o_write_enable) begin
            cnt_d = cnt_q + FILL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/flatten_fc_ibuf_ctrl.sv
// Sequencer for the flatten-to-FC input buffer: fill every channel, then stream
// the buffer bit-plane by bit-plane into the crossbars, firing CIM after each plane.
module flatten_fc_ibuf_ctrl
    import flatten_fc_pkg::*;
#(
    parameter int DATA_SIZE      = 8,
    parameter int IMG_SIZE       = 784,
    parameter int INPUT_CHANNELS = 2,
    parameter int XBAR_SIZE      = 128,
    parameter int BUS_WIDTH      = 16,
    parameter int V_CIM_TILES    = ceil_div(INPUT_CHANNELS * IMG_SIZE, XBAR_SIZE),
    parameter int NUM_ADDR       = ceil_div(INPUT_CHANNELS * IMG_SIZE, BUS_WIDTH * V_CIM_TILES),
    parameter int ADDR_WIDTH     = (NUM_ADDR <= 1) ? 1 : $clog2(NUM_ADDR),
    parameter int COUNT_WIDTH    = (DATA_SIZE == 1) ? 1 : $clog2(DATA_SIZE),
    parameter int FILL_WIDTH     = $clog2(IMG_SIZE + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [INPUT_CHANNELS-1:0] i_valid,
    output logic [INPUT_CHANNELS-1:0] o_ready,
    output logic [INPUT_CHANNELS-1:0] o_write_enable,
    output logic [ADDR_WIDTH-1:0]     o_ibuf_addr,
    output logic [COUNT_WIDTH-1:0]    o_count,
    output logic                      o_ibuf_valid,
    input  logic                      i_ibuf_ready,
    output logic                      o_cim_start,
    input  logic                      i_cim_done,
    output logic                      o_busy,
    output logic                      o_layer_done
);

    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(NUM_ADDR - 1);
    localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(DATA_SIZE - 1);

    ctrl_state_t              state_q, state_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [INPUT_CHANNELS-1:0] full_vec;
    logic                     fill_en;
    logic                     clr_fill;
    logic                     all_full;

    assign fill_en  = (state_q == FILL);
    assign clr_fill = (state_q == DONE);
    assign all_full = &full_vec;

    // Counters only advance in FILL, so FIFO contents are frozen during readout.
    generate
        for (genvar gi = 0; gi < INPUT_CHANNELS; gi++) begin : g_fill
            ibuf_fill_counter #(
                .IMG_SIZE   (IMG_SIZE),
                .FILL_WIDTH (FILL_WIDTH)
            ) u_fill_counter (
                .clk            (clk),
                .rst            (rst),
                .i_fill_en      (fill_en),
                .i_valid        (i_valid[gi]),
                .i_clr          (clr_fill),
                .o_ready        (o_ready[gi]),
                .o_write_enable (o_write_enable[gi]),
                .o_full         (full_vec[gi])
            );
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        count_d = count_q;
        unique case (state_q)
            FILL: begin
                if (all_full) begin
                    state_d = STREAM;
                    addr_d  = '0;
                    count_d = '0;
                end
            end
            STREAM: begin
                if (i_ibuf_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        state_d = EXEC;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            EXEC: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_cim_done) begin
                    if (count_q == LAST_COUNT) begin
                        count_d = '0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q + COUNT_WIDTH'(1);
                        state_d = STREAM;
                    end
                end
            end
            DONE: begin
                state_d = FILL;
            end
            default: begin
                state_d = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            addr_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

    assign o_ibuf_addr  = addr_q;
    assign o_count      = count_q;
    assign o_ibuf_valid = (state_q == STREAM);
    assign o_cim_start  = (state_q == EXEC);
    assign o_layer_done = (state_q == DONE);
    assign o_busy       = (state_q != FILL);

endmodule

// File: tb/tb_flatten_fc_ibuf_ctrl.sv
// Randomized scoreboard bench for flatten_fc_ibuf_ctrl using a small buffer geometry.
module tb_flatten_fc_ibuf_ctrl;

    localparam int DS  = 2;
    localparam int IMG = 4;
    localparam int CH  = 2;
    localparam int XB  = 4;
    localparam int BW  = 2;
    localparam int VT  = (CH * IMG + XB - 1) / XB;
    localparam int NA  = (CH * IMG + BW * VT - 1) / (BW * VT);
    localparam int AW  = (NA <= 1) ? 1 : $clog2(NA);
    localparam int CW  = (DS == 1) ? 1 : $clog2(DS);
    localparam int NUM_LAYERS = 6;
    localparam int MAX_CYC    = 5000;

    localparam int EV_BEAT  = 0;
    localparam int EV_START = 1;
    localparam int EV_LDONE = 2;

    typedef struct {
        int kind;
        int addr;
        int cnt;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [CH-1:0] i_valid;
    logic [CH-1:0] o_ready;
    logic [CH-1:0] o_write_enable;
    logic [AW-1:0] o_ibuf_addr;
    logic [CW-1:0] o_count;
    logic          o_ibuf_valid;
    logic          i_ibuf_ready;
    logic          o_cim_start;
    logic          i_cim_done;
    logic          o_busy;
    logic          o_layer_done;

    always #5 clk = ~clk;

    flatten_fc_ibuf_ctrl #(
        .DATA_SIZE      (DS),
        .IMG_SIZE       (IMG),
        .INPUT_CHANNELS (CH),
        .XBAR_SIZE      (XB),
        .BUS_WIDTH      (BW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_valid        (i_valid),
        .o_ready        (o_ready),
        .o_write_enable (o_write_enable),
        .o_ibuf_addr    (o_ibuf_addr),
        .o_count        (o_count),
        .o_ibuf_valid   (o_ibuf_valid),
        .i_ibuf_ready   (i_ibuf_ready),
        .o_cim_start    (o_cim_start),
        .i_cim_done     (i_cim_done),
        .o_busy         (o_busy),
        .o_layer_done   (o_layer_done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Reference model: per-channel element counts and the expected event stream.
    ev_t exp_q[$];
    int  cnt_m [CH];
    int  full_age = 0;
    bit  stalled  = 0;

    task automatic push_layer();
        for (int p = 0; p < DS; p++) begin
            for (int a = 0; a < NA; a++) exp_q.push_back('{EV_BEAT, a, p});
            exp_q.push_back('{EV_START, 0, p});
        end
        exp_q.push_back('{EV_LDONE, 0, 0});
    endtask

    function automatic int enc(input int kind, input int addr, input int cnt);
        return (kind << 16) | (addr << 8) | cnt;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            foreach (cnt_m[c]) cnt_m[c] = 0;
            exp_q.delete();
            full_age = 0;
            stalled  = 0;
        end else begin
            bit      all_full;
            bit      ldone_seen;
            logic [CH-1:0] rdy_e, we_e;
            ev_t     f;
            all_full   = 1'b1;
            ldone_seen = 1'b0;
            for (int c = 0; c < CH; c++) begin
                rdy_e[c] = (cnt_m[c] != IMG);
                if (cnt_m[c] != IMG) all_full = 1'b0;
            end
            we_e = i_valid & rdy_e;
            chk("o_ready", int'(o_ready), int'(rdy_e));
            chk("o_write_enable", int'(o_write_enable), int'(we_e));
            chk("o_busy", int'(o_busy), int'(all_full && full_age >= 1));
            if (all_full && full_age == 0) push_layer();
            if (stalled) chk("valid_hold", int'(o_ibuf_valid), 1);

            f = (exp_q.size() > 0) ? exp_q[0] : '{-1, 0, 0};
            if (o_ibuf_valid) begin
                chk("beat", enc(EV_BEAT, int'(o_ibuf_addr), int'(o_count)), enc(f.kind, f.addr, f.cnt));
                stalled = !i_ibuf_ready;
                if (i_ibuf_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            end else begin
                stalled = 1'b0;
            end
            f = (exp_q.size() > 0) ? exp_q[0] : '{-1, 0, 0};
            if (o_cim_start) begin
                chk("cim_start", EV_START, f.kind);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            f = (exp_q.size() > 0) ? exp_q[0] : '{-1, 0, 0};
            if (o_layer_done) begin
                chk("layer_done", EV_LDONE, f.kind);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                ldone_seen = 1'b1;
            end

            for (int c = 0; c < CH; c++) if (we_e[c]) cnt_m[c]++;
            if (ldone_seen) begin
                foreach (cnt_m[c]) cnt_m[c] = 0;
                full_age = 0;
            end else if (all_full) begin
                full_age++;
            end
        end
    end

    // Stimulus: randomized upstream valids, downstream stalls and CIM latency.
    int layers = 0;
    int cyc    = 0;
    int lcyc   = 0;
    bit pending  = 0;
    bit injected = 0;
    int lat      = 0;

    initial begin
        rst          = 1'b1;
        i_valid      = '0;
        i_ibuf_ready = 1'b0;
        i_cim_done   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        while (layers < NUM_LAYERS && cyc < MAX_CYC) begin
            @(posedge clk);
            #1;
            cyc++;
            lcyc++;
            if (rst) begin
                rst    = 1'b0;
                layers++;
                lcyc   = 0;
                $display("layer %0d aborted by reset at cycle %0d", layers, cyc);
            end else if (o_layer_done) begin
                layers++;
                lcyc = 0;
                $display("layer %0d done at cycle %0d", layers, cyc);
            end

            case (layers)
                0: i_valid = '1;
                1: i_valid = (lcyc < 12) ? CH'(1) : CH'($urandom);
                default: i_valid = CH'($urandom);
            endcase
            case (layers)
                0: i_ibuf_ready = 1'b1;
                2: i_ibuf_ready = ($urandom_range(0, 5) == 0);
                default: i_ibuf_ready = ($urandom_range(0, 3) != 0);
            endcase

            if (o_cim_start) begin
                pending    = 1'b1;
                lat        = (layers == 0) ? 3 : $urandom_range(1, 4);
                i_cim_done = 1'b0;
            end else if (pending) begin
                if (layers == 3 && !injected) begin
                    rst        = 1'b1;
                    injected   = 1'b1;
                    pending    = 1'b0;
                    i_cim_done = 1'b0;
                end else begin
                    lat--;
                    i_cim_done = (lat == 0);
                    if (lat == 0) pending = 1'b0;
                end
            end else begin
                i_cim_done = ($urandom_range(0, 5) == 0);
            end
        end
        i_valid    = '0;
        i_cim_done = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("layers_completed_in_budget", (cyc < MAX_CYC) ? 1 : 0, 1);
        chk("events_outstanding", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
